// File: rtl/sa_pkg.sv
// Shared widths and FSM state type for the systolic-array result reader.
// Row indices are always carried at IDX_W bits regardless of NUM_ROWS.
package sa_pkg;

   localparam int DW    = 16;
   localparam int LANES = 16;
   localparam int IDX_W = 5;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      SEND,
      FIN
   } state_t;

endpackage

// File: rtl/sa_result_reader.sv
// Drains NUM_ROWS rows from the array result buffer and serializes each
// row lane by lane onto a valid/ready stream, pulsing done at the end.
module sa_result_reader
   import sa_pkg::*;
#(
   parameter int NUM_ROWS = 8,
   parameter int LANES    = sa_pkg::LANES,
   parameter int DW       = sa_pkg::DW
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    start,
   output logic                    rd_en,
   output logic [IDX_W-1:0]        rd_idx,
   input  logic [LANES*DW-1:0]     rd_data,
   output logic [DW-1:0]           dout,
   output logic                    dout_valid,
   input  logic                    dout_ready,
   output logic                    dout_last,
   output logic                    busy,
   output logic                    done
);

   localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [LW-1:0]    LANE_MAX = LW'(LANES - 1);
   localparam logic [IDX_W-1:0] ROW_MAX  = IDX_W'(NUM_ROWS - 1);

   state_t           state, state_n;
   logic [IDX_W-1:0] row, row_n;
   logic [LW-1:0]    lane, lane_n;
   logic [DW-1:0]    row_buf [LANES];
   logic             cap;
   logic             done_q;

   always_comb begin
      state_n = state;
      row_n   = row;
      lane_n  = lane;
      cap     = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_n = REQ;
               row_n   = '0;
            end
         end
         REQ: state_n = WAIT;
         WAIT: begin
            cap     = 1'b1;
            lane_n  = '0;
            state_n = SEND;
         end
         SEND: begin
            if (dout_ready) begin
               // the last lane holds its count; only WAIT clears it
               if (lane == LANE_MAX) begin
                  if (row == ROW_MAX) begin
                     state_n = FIN;
                  end else begin
                     row_n   = row + 1'b1;
                     state_n = REQ;
                  end
               end else begin
                  lane_n = lane + 1'b1;
               end
            end
         end
         FIN: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         row    <= '0;
         lane   <= '0;
         done_q <= 1'b0;
         for (int k = 0; k < LANES; k++) begin
            row_buf[k] <= '0;
         end
      end else if (en) begin
         state  <= state_n;
         row    <= row_n;
         lane   <= lane_n;
         done_q <= (state == FIN);
         if (cap) begin
            for (int k = 0; k < LANES; k++) begin
               row_buf[k] <= rd_data[k*DW +: DW];
            end
         end
      end
   end

   assign rd_en      = (state == REQ);
   assign rd_idx     = row;
   assign dout       = row_buf[lane];
   assign dout_valid = (state == SEND);
   assign dout_last  = dout_valid && (row == ROW_MAX) && (lane == LANE_MAX);
   assign busy       = (state != IDLE);
   assign done       = done_q;

endmodule
